// File: rtl/issue_queue_multi.sv
// issue_queue_multi: collapsing, age-ordered issue queue with wakeup tracking,
// oldest-first multi-issue select and branch squash.
// Optional feature macro IQ_ISSUE_WAKE_EN: slots issuing this cycle broadcast
// their destination tag as an extra wakeup (single-cycle back-to-back issue).
module issue_queue_multi #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned ENQ_W     = 4,
  parameter int unsigned ISSUE_W   = 2,
  parameter int unsigned WAKE_W    = 4,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ENQ_W-1:0]             IN_enqValid,
  input  logic [ENQ_W*7-1:0]           IN_enqTagA,
  input  logic [ENQ_W*7-1:0]           IN_enqTagB,
  input  logic [ENQ_W-1:0]             IN_enqAvailA,
  input  logic [ENQ_W-1:0]             IN_enqAvailB,
  input  logic [ENQ_W*7-1:0]           IN_enqTagDst,
  input  logic [ENQ_W*7-1:0]           IN_enqSqN,
  input  logic [ENQ_W*PAYLOAD_W-1:0]   IN_enqPayload,
  input  logic [WAKE_W-1:0]            IN_wakeValid,
  input  logic [WAKE_W*7-1:0]          IN_wakeTag,
  input  logic                         IN_branchValid,
  input  logic [6:0]                   IN_branchSqN,
  input  logic                         IN_stall,
  output logic                         OUT_full,
  output logic [$clog2(SIZE):0]        OUT_count,
  output logic [ISSUE_W-1:0]           OUT_issueValid,
  output logic [ISSUE_W*7-1:0]         OUT_issueTagDst,
  output logic [ISSUE_W*7-1:0]         OUT_issueSqN,
  output logic [ISSUE_W*PAYLOAD_W-1:0] OUT_issuePayload
);

  localparam int unsigned TAG_W = 7;
  localparam int unsigned CNT_W = $clog2(SIZE) + 1;
  localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned SEL_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
`ifdef IQ_ISSUE_WAKE_EN
  localparam int unsigned NWAKE = WAKE_W + ISSUE_W;
`else
  localparam int unsigned NWAKE = WAKE_W;
`endif

  typedef struct packed {
    logic [TAG_W-1:0]     tag_a;
    logic [TAG_W-1:0]     tag_b;
    logic                 avail_a;
    logic                 avail_b;
    logic [TAG_W-1:0]     tag_dst;
    logic [TAG_W-1:0]     sqn;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag_dst;
    logic [TAG_W-1:0]     sqn;
    logic [PAYLOAD_W-1:0] payload;
  } slot_t;

  entry_t [SIZE-1:0]    ent_q, ent_d;
  slot_t  [ISSUE_W-1:0] slot_q, slot_d;
  logic   [CNT_W-1:0]   count_q, count_d;

  logic [NWAKE-1:0]            wake_v;
  logic [NWAKE-1:0][TAG_W-1:0] wake_t;

  // a is strictly younger than b under 7-bit wrap-around ordering
  function automatic logic younger(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] diff;
    diff = a - b;
    return !diff[TAG_W-1] && (diff != '0);
  endfunction

  // any active wakeup broadcast matching tag
  function automatic logic tag_hit(input logic [TAG_W-1:0] tag,
                                   input logic [NWAKE-1:0] v,
                                   input logic [NWAKE-1:0][TAG_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NWAKE; k++) hit = hit | (v[k] && (t[k] == tag));
    return hit;
  endfunction

  // Collect wakeup broadcasts for this cycle
  always_comb begin
    wake_v = '0;
    wake_t = '0;
    for (int k = 0; k < WAKE_W; k++) begin
      wake_v[k] = IN_wakeValid[k];
      wake_t[k] = IN_wakeTag[k*TAG_W +: TAG_W];
    end
`ifdef IQ_ISSUE_WAKE_EN
    for (int s = 0; s < ISSUE_W; s++) begin
      wake_v[WAKE_W+s] = slot_q[s].valid && !IN_stall && (slot_q[s].tag_dst != '0);
      wake_t[WAKE_W+s] = slot_q[s].tag_dst;
    end
`endif
  end

  assign OUT_full = (count_q > CNT_W'(SIZE - ENQ_W));

  // Merge wakeups, squash or select, collapse survivors, then append enqueues
  always_comb begin : p_next
    entry_t      e;
    int unsigned n;
    int unsigned nsel;
    ent_d   = '0;
    slot_d  = slot_q;
    count_d = count_q;
    n       = 0;
    nsel    = 0;
    e       = '0;

    if (IN_branchValid) begin
      for (int s = 0; s < ISSUE_W; s++)
        if (!IN_stall || younger(slot_q[s].sqn, IN_branchSqN)) slot_d[s] = '0;
    end else if (!IN_stall) begin
      slot_d = '0;
    end

    for (int i = 0; i < SIZE; i++) begin
      e = ent_q[i];
      e.avail_a = e.avail_a | tag_hit(e.tag_a, wake_v, wake_t);
      e.avail_b = e.avail_b | tag_hit(e.tag_b, wake_v, wake_t);
      if (i < int'(count_q)) begin
        if (IN_branchValid) begin
          if (!younger(e.sqn, IN_branchSqN)) begin
            ent_d[IDX_W'(n)] = e;
            n++;
          end
        end else if (!IN_stall && (nsel < ISSUE_W) && e.avail_a && e.avail_b) begin
          slot_d[SEL_W'(nsel)].valid   = 1'b1;
          slot_d[SEL_W'(nsel)].tag_dst = e.tag_dst;
          slot_d[SEL_W'(nsel)].sqn     = e.sqn;
          slot_d[SEL_W'(nsel)].payload = e.payload;
          nsel++;
        end else begin
          ent_d[IDX_W'(n)] = e;
          n++;
        end
      end
    end

    if (!IN_branchValid && !OUT_full) begin
      for (int p = 0; p < ENQ_W; p++) begin
        if (IN_enqValid[p]) begin
          e.tag_a   = IN_enqTagA[p*TAG_W +: TAG_W];
          e.tag_b   = IN_enqTagB[p*TAG_W +: TAG_W];
          e.avail_a = IN_enqAvailA[p] | tag_hit(e.tag_a, wake_v, wake_t);
          e.avail_b = IN_enqAvailB[p] | tag_hit(e.tag_b, wake_v, wake_t);
          e.tag_dst = IN_enqTagDst[p*TAG_W +: TAG_W];
          e.sqn     = IN_enqSqN[p*TAG_W +: TAG_W];
          e.payload = IN_enqPayload[p*PAYLOAD_W +: PAYLOAD_W];
          ent_d[IDX_W'(n)] = e;
          n++;
        end
      end
    end

    count_d = CNT_W'(n);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '0;
      slot_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  // Flatten registered issue slots onto the output buses
  always_comb begin
    OUT_count = count_q;
    for (int s = 0; s < ISSUE_W; s++) begin
      OUT_issueValid[s]                          = slot_q[s].valid;
      OUT_issueTagDst[s*TAG_W +: TAG_W]          = slot_q[s].tag_dst;
      OUT_issueSqN[s*TAG_W +: TAG_W]             = slot_q[s].sqn;
      OUT_issuePayload[s*PAYLOAD_W +: PAYLOAD_W] = slot_q[s].payload;
    end
  end

endmodule
